clock_mode_ctrl: RTL and testbench

Top-level sequencer for the digital clock. Owns the live BCD time registers and the 1 Hz prescaler, and conditions the three raw push-buttons (synchronise, debounce, rising-edge detect). It steps the user through RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN, editing a shadow copy of the time and committing it on exit. It drives the display digits and mode indication, and is 24-hour only.

---
 rtl/clock_mode_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - 24-hour clock sequencer: button conditioning, 1 Hz prescaler,
// live/shadow BCD time and RUN/SET_HOUR/SET_MIN/SET_SEC mode FSM.
module clock_mode_ctrl #(
  parameter int TICK_DIV   = 100000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       tens_btn,
  input  logic       ones_btn,
  output logic [1:0] hour1,
  output logic [3:0] hour2,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic [3:0] sec1,
  output logic [3:0] sec2,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HOUR = 2'b01,
    S_MIN  = 2'b10,
    S_SEC  = 2'b11
  } state_t;

  state_t r_state, w_next;

  logic [2:0]         w_raw;
  logic [2:0]         r_sync1, r_sync2, r_deb, r_deb_d;
  logic [2:0][DW-1:0] r_dcnt;
  logic [2:0]         w_press;

  logic [PW-1:0] r_presc;
  logic          w_wrap, w_capture, w_commit, w_edit;

  logic [1:0] r_h1, r_sh_h1, w_nh1;
  logic [3:0] r_h2, r_m1, r_m2, r_s1, r_s2;
  logic [3:0] r_sh_h2, r_sh_m1, r_sh_m2, r_sh_s1, r_sh_s2;
  logic [3:0] w_nh2, w_nm1, w_nm2, w_ns1, w_ns2;

  // bit 0 mode, bit 1 tens, bit 2 ones
  assign w_raw   = {ones_btn, tens_btn, mode_btn};
  assign w_press = r_deb & ~r_deb_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_dcnt[i] == DW'(DEB_CYCLES - 1)) begin
            r_deb[i]  <= ~r_deb[i];
            r_dcnt[i] <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + 1'b1;
          end
        end else begin
          r_dcnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_next;
  end

  // A mode press always wins over a same-cycle edit press.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_commit  = 1'b0;
    w_edit    = 1'b0;
    if (w_press[0]) begin
      unique case (r_state)
        S_RUN:  begin w_next = S_HOUR; w_capture = 1'b1; end
        S_HOUR: w_next = S_MIN;
        S_MIN:  w_next = S_SEC;
        S_SEC:  begin w_next = S_RUN; w_commit = 1'b1; end
      endcase
    end else begin
      w_edit = (r_state != S_RUN);
    end
  end

  assign w_wrap = (r_presc == PW'(TICK_DIV - 1));
  assign tick   = w_wrap & ~w_commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_presc <= '0;
    else if (w_commit || w_wrap) r_presc <= '0;
    else                        r_presc <= r_presc + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h1 <= '0; r_h2 <= '0; r_m1 <= '0; r_m2 <= '0; r_s1 <= '0; r_s2 <= '0;
    end else if (w_commit) begin
      r_h1 <= r_sh_h1; r_h2 <= r_sh_h2; r_m1 <= r_sh_m1;
      r_m2 <= r_sh_m2; r_s1 <= r_sh_s1; r_s2 <= r_sh_s2;
    end else if (tick) begin
      if (r_s2 != 4'd9) r_s2 <= r_s2 + 4'd1;
      else begin
        r_s2 <= 4'd0;
        if (r_s1 != 4'd5) r_s1 <= r_s1 + 4'd1;
        else begin
          r_s1 <= 4'd0;
          if (r_m2 != 4'd9) r_m2 <= r_m2 + 4'd1;
          else begin
            r_m2 <= 4'd0;
            if (r_m1 != 4'd5) r_m1 <= r_m1 + 4'd1;
            else begin
              r_m1 <= 4'd0;
              if (r_h1 == 2'd2 && r_h2 == 4'd3) begin
                r_h1 <= 2'd0;
                r_h2 <= 4'd0;
              end else if (r_h2 == 4'd9) begin
                r_h2 <= 4'd0;
                r_h1 <= r_h1 + 2'd1;
              end else begin
                r_h2 <= r_h2 + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Tens is applied before ones so the hour-ones limit sees the new tens digit.
  always_comb begin
    w_nh1 = r_sh_h1; w_nh2 = r_sh_h2; w_nm1 = r_sh_m1;
    w_nm2 = r_sh_m2; w_ns1 = r_sh_s1; w_ns2 = r_sh_s2;
    if (w_edit) begin
      case (r_state)
        S_HOUR: begin
          if (w_press[1]) begin
            if (r_sh_h1 == 2'd2) w_nh1 = 2'd0;
            else                 w_nh1 = r_sh_h1 + 2'd1;
            if (w_nh1 == 2'd2 && w_nh2 > 4'd3) w_nh2 = 4'd3;
          end
          if (w_press[2]) begin
            if (w_nh1 == 2'd2) begin
              if (w_nh2 >= 4'd3) w_nh2 = 4'd0;
              else               w_nh2 = w_nh2 + 4'd1;
            end else begin
              if (w_nh2 == 4'd9) w_nh2 = 4'd0;
              else               w_nh2 = w_nh2 + 4'd1;
            end
          end
        end
        S_MIN: begin
          if (w_press[1]) begin
            if (r_sh_m1 == 4'd5) w_nm1 = 4'd0;
            else                 w_nm1 = r_sh_m1 + 4'd1;
          end
          if (w_press[2]) begin
            if (r_sh_m2 == 4'd9) w_nm2 = 4'd0;
            else                 w_nm2 = r_sh_m2 + 4'd1;
          end
        end
        S_SEC: begin
          if (w_press[1]) begin
            if (r_sh_s1 == 4'd5) w_ns1 = 4'd0;
            else                 w_ns1 = r_sh_s1 + 4'd1;
          end
          if (w_press[2]) begin
            if (r_sh_s2 == 4'd9) w_ns2 = 4'd0;
            else                 w_ns2 = r_sh_s2 + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_h1 <= '0; r_sh_h2 <= '0; r_sh_m1 <= '0;
      r_sh_m2 <= '0; r_sh_s1 <= '0; r_sh_s2 <= '0;
    end else if (w_capture) begin
      r_sh_h1 <= r_h1; r_sh_h2 <= r_h2; r_sh_m1 <= r_m1;
      r_sh_m2 <= r_m2; r_sh_s1 <= r_s1; r_sh_s2 <= r_s2;
    end else begin
      r_sh_h1 <= w_nh1; r_sh_h2 <= w_nh2; r_sh_m1 <= w_nm1;
      r_sh_m2 <= w_nm2; r_sh_s1 <= w_ns1; r_sh_s2 <= w_ns2;
    end
  end

  always_comb begin
    if (r_state == S_RUN) begin
      hour1 = r_h1; hour2 = r_h2; min1 = r_m1; min2 = r_m2; sec1 = r_s1; sec2 = r_s2;
    end else begin
      hour1 = r_sh_h1; hour2 = r_sh_h2; min1 = r_sh_m1;
      min2  = r_sh_m2; sec1  = r_sh_s1; sec2 = r_sh_s2;
    end
  end

  assign mode = r_state;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - self-checking bench for clock_mode_ctrl against a
// seconds-of-day reference model.
module tb_clock_mode_ctrl;
  localparam int TD  = 4;
  localparam int DB  = 3;
  localparam int LAT = 2 + DB + 1;

  logic       clk = 1'b0, reset = 1'b1;
  logic       mode_btn = 1'b0, tens_btn = 1'b0, ones_btn = 1'b0;
  logic [1:0] hour1, mode;
  logic [3:0] hour2, min1, min2, sec1, sec2;
  logic       tick;
  logic [21:0] w_disp;

  clock_mode_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .tens_btn(tens_btn), .ones_btn(ones_btn),
    .hour1(hour1), .hour2(hour2), .min1(min1), .min2(min2), .sec1(sec1), .sec2(sec2),
    .mode(mode), .tick(tick)
  );

  assign w_disp = {hour1, hour2, min1, min2, sec1, sec2};
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, ref_cyc = 0, ref_secs = 0;
  int m_mode = 0;
  int m_sh[3];

  function automatic int live_at(int c);
    return (ref_secs + (c - ref_cyc) / TD) % 86400;
  endfunction

  function automatic logic [21:0] bcd(int h, int m, int s);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic void apply(int f, bit t, bit o);
    int ht, ho, lim;
    ht = m_sh[f] / 10;
    ho = m_sh[f] % 10;
    if (f == 0) begin
      if (t) begin
        ht = (ht + 1) % 3;
        if (ht == 2 && ho > 3) ho = 3;
      end
      lim = (ht == 2) ? 4 : 10;
      if (o) ho = (ho + 1) % lim;
    end else begin
      if (t) ht = (ht + 1) % 6;
      if (o) ho = (ho + 1) % 10;
    end
    m_sh[f] = ht * 10 + ho;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_disp(string tag);
    int t;
    logic [21:0] e;
    if (m_mode == 0) begin
      t = live_at(cyc);
      e = bcd(t / 3600, (t / 60) % 60, t % 60);
    end else begin
      e = bcd(m_sh[0], m_sh[1], m_sh[2]);
    end
    chk({tag, "_disp"}, w_disp, e);
    chk({tag, "_mode"}, mode, m_mode);
  endtask

  task automatic run_check(string tag, int n);
    repeat (n) begin
      edge_();
      chk({tag, "_tick"}, tick, ((cyc - ref_cyc) % TD == TD - 1) ? 1 : 0);
      chk_disp(tag);
    end
  endtask

  task automatic settle();
    repeat (LAT + 2) edge_();
  endtask

  task automatic press(bit m, bit t, bit o);
    int old, v;
    bit commit;
    commit = m && (m_mode == 3);
    // align so the commit cycle lands where the prescaler would otherwise wrap
    if (commit) while (((cyc - ref_cyc) % TD) != 2) edge_();
    old = m_mode;
    mode_btn = m; tens_btn = t; ones_btn = o;
    repeat (LAT - 1) edge_();
    chk("pre_latency_mode", mode, old);
    if (commit) chk("commit_tick", tick, 0);
    edge_();
    if (m) begin
      if (m_mode == 0) begin
        v = live_at(cyc - 1);
        m_sh[0] = v / 3600; m_sh[1] = (v / 60) % 60; m_sh[2] = v % 60;
        m_mode = 1;
      end else if (m_mode == 3) begin
        ref_secs = m_sh[0] * 3600 + m_sh[1] * 60 + m_sh[2];
        ref_cyc = cyc;
        m_mode = 0;
      end else begin
        m_mode++;
      end
    end else if (m_mode != 0) begin
      apply(m_mode - 1, t, o);
    end
    chk_disp("press");
    mode_btn = 0; tens_btn = 0; ones_btn = 0;
  endtask

  task automatic set_field(int f, int target);
    int guard;
    guard = 0;
    while (m_sh[f] != target && guard < 40) begin
      if (m_sh[f] / 10 != target / 10) press(0, 1, 0);
      else                             press(0, 0, 1);
      settle();
      guard++;
    end
  endtask

  task automatic set_time(int h, int m, int s);
    press(1, 0, 0); settle();
    set_field(0, h);
    press(1, 0, 0); settle();
    set_field(1, m);
    press(1, 0, 0); settle();
    set_field(2, s);
    press(1, 0, 0);
  endtask

  initial begin
    int n, tr, tedge, k0, v;
    logic [1:0] pm;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_disp", w_disp, 0);
    chk("reset_mode", mode, 0);
    chk("reset_tick", tick, 0);
    reset = 1'b0;
    cyc = 0; ref_cyc = 0; ref_secs = 0; m_mode = 0;

    run_check("run", 240);
    chk("run240", w_disp, bcd(0, 1, 0));

    press(0, 1, 1);
    settle();

    n = $urandom_range(1, 4);
    repeat (n) begin
      mode_btn = 1; edge_();
      mode_btn = 0; edge_();
    end
    chk("glitch_mode", mode, 0);
    mode_btn = 1; k0 = cyc; pm = mode; tr = 0; tedge = -1;
    repeat (50) begin
      edge_();
      if (mode !== pm) begin tr++; tedge = cyc; pm = mode; end
    end
    chk("hold_presses", tr, 1);
    chk("hold_latency", tedge - k0, LAT);
    m_mode = 1;
    v = live_at(k0 + LAT - 1);
    m_sh[0] = v / 3600; m_sh[1] = (v / 60) % 60; m_sh[2] = v % 60;
    chk_disp("hold");
    mode_btn = 0;
    repeat (20) edge_();
    chk_disp("release");

    set_field(0, 19);
    press(0, 1, 0);
    chk("hour_tens_clamp", {hour1, hour2}, 6'h23);
    settle();
    press(0, 0, 1);
    chk("hour_ones_wrap", {hour1, hour2}, 6'h20);
    settle();
    set_field(0, 13);
    press(0, 1, 1);
    chk("hour_tens_ones", {hour1, hour2}, 6'h20);
    settle();

    press(1, 0, 0); settle();
    set_field(1, 59);
    press(0, 1, 0);
    chk("min_tens_wrap", {min1, min2}, 8'h09);
    settle();
    press(0, 0, 1);
    chk("min_ones_wrap", {min1, min2}, 8'h00);
    settle();
    press(1, 0, 1);
    chk("mode_wins", mode, 3);
    chk("mode_wins_min", {min1, min2}, 8'h00);
    settle();
    set_field(2, $urandom_range(0, 59));
    press(1, 0, 0);
    run_check("run2", $urandom_range(10, 40));

    set_time(23, 59, 58);
    chk("pre_wrap", w_disp, bcd(23, 59, 58));
    run_check("wrap", 4);
    chk("wrap_59", w_disp, bcd(23, 59, 59));
    run_check("wrap", 4);
    chk("wrap_00", w_disp, 0);

    set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
    run_check("rnd", $urandom_range(20, 80));

    set_time(12, 34, 56);
    chk("commit_123456", w_disp, bcd(12, 34, 56));
    run_check("post", 3);
    chk("hold_56", w_disp, bcd(12, 34, 56));
    run_check("post", 1);
    chk("adv_57", w_disp, bcd(12, 34, 57));
    run_check("post", 8);

    press(1, 0, 0); settle();
    press(1, 0, 0); settle();
    press(1, 0, 0); settle();
    press(0, 1, 0); settle();
    reset = 1'b1;
    #1;
    chk("midreset_disp", w_disp, 0);
    chk("midreset_mode", mode, 0);
    chk("midreset_tick", tick, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0; ref_cyc = 0; ref_secs = 0; m_mode = 0;
    run_check("after_reset", 12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
